sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 reqN_r_en, reqN_w_en (N=0,1)  input  1 each  read / write request from requester N.
REQ-004 reqN_addr  input  32  byte address from requester N.
REQ-005 reqN_wdata  input  32  store value from requester N.
REQ-006 reqN_hit  input  1  cache-hit flag for requester N's read.
REQ-007 reqN_rdata  output  32  read data returned to requester N.
REQ-008 reqN_ready  output  1  one-cycle completion pulse to requester N.
REQ-009 MEM_R_EN, MEM_W_EN  output  1 each  read / write enable to the SRAM controller.
REQ-010 ALU_res, ST_Value  output  32 each  address / store value to the SRAM controller.
REQ-011 hit  output  1  granted requester's hit flag, forwarded to the SRAM controller.
REQ-012 Ready  input  1  SRAM controller completion.
REQ-013 read_data  input  32  SRAM controller read result.
REQ-014 grant  output  1  index of the current or last granted requester.

Function
REQ-015 Requester N is active when reqN_r_en | reqN_w_en.
- A requester holds all its request inputs stable until it sees its reqN_ready pulse.
- It deasserts the request on the edge that ends the pulse.
REQ-016 FSM states:
- IDLE: enables low.
- BUSY: drive granted request.
- RELEASE: enables low, reqN_ready pulse.
REQ-017 Transitions:
- IDLE->BUSY when any requester is active.
- BUSY->RELEASE on the cycle Ready=1.
- RELEASE->IDLE unconditionally.
REQ-018 Arbitration is evaluated in IDLE only.
- Single active requester: it wins.
- Both active: the requester other than last_grant wins.
- grant is registered on the IDLE->BUSY edge.
REQ-019 In BUSY:
- MEM_W_EN = reqG_w_en.
- MEM_R_EN = reqG_r_en & ~reqG_w_en (write precedence).
- ALU_res = reqG_addr, ST_Value = reqG_wdata, hit = reqG_hit, where G = grant.
REQ-020 In IDLE and RELEASE: MEM_R_EN=MEM_W_EN=hit=0; ALU_res and ST_Value hold the last granted values.
REQ-021 In BUSY with Ready=1, on that edge:
- reqG_rdata <= read_data.
- last_grant <= G.
- State goes to RELEASE.
REQ-022 reqG_ready=1 for exactly the RELEASE cycle; the non-granted reqN_ready stays 0.
REQ-023 reqN_rdata holds its value until requester N's next completion; it is unchanged after writes.
REQ-024 Latency, request first seen in IDLE at cycle 0:
- Read hit: Ready in cycle 1, reqN_ready in cycle 2.
- Otherwise: reqN_ready one cycle after the first Ready seen in BUSY.
REQ-025 Enables are low for at least one cycle (RELEASE) between transactions, so the controller never re-triggers on a stale request.
REQ-026 A request arriving from the other requester during BUSY or RELEASE is not dropped; it is granted at the next IDLE.
REQ-027 Back-to-back: with both requesters continuously active, grants alternate 0,1,0,1,...
- Each transaction occupies a minimum of 3 cycles (IDLE, BUSY, RELEASE).
REQ-028 A requester dropping its request mid-BUSY is a protocol violation. The arbiter still waits for Ready and completes normally.

Reset
REQ-029 rst=1 at a rising edge forces the following, regardless of state, including mid-BUSY:
- state=IDLE, last_grant=1, grant=0.
- reqN_rdata=0, reqN_ready=0.
- MEM_R_EN=MEM_W_EN=hit=0, ALU_res=ST_Value=0.
REQ-030 With last_grant=1 after reset, requester 0 wins the first simultaneous request.
REQ-031 The SRAM controller shares rst; no in-flight transaction survives reset, and no reqN_ready is issued for it.

Structure
REQ-032 A shared package holds:
- State encodings IDLE=2'd0, BUSY=2'd1, RELEASE=2'd2.
- NUM_REQ=2.
- ADDR_W=32, DATA_W=32.
REQ-033 One sub-module, rr_pick: combinational two-way round-robin select (active vector, last_grant -> winner, any).
REQ-034 All outputs to the SRAM controller are driven from registered state plus the grant mux; there is no combinational path from reqN inputs to MEM_*_EN outside BUSY.

Verification
REQ-035 Reset then req0 write, addr 0x100, data 0xDEADBEEF; model Ready 6 cycles later.
- Expect MEM_W_EN=1 with ALU_res=0x100 and ST_Value=0xDEADBEEF throughout BUSY.
- Expect req0_ready pulse exactly 1 cycle.
REQ-036 req1 read hit (req1_hit=1), Ready combinational in cycle 1.
- Expect req1_ready in cycle 2.
- Expect req1_rdata = read_data sampled at that edge (e.g. 0x12345678).
REQ-037 req0 and req1 both reading, held active for 4 transactions.
- Expect grant sequence 0,1,0,1.
- Expect one cycle with MEM_R_EN=0 between each transaction.
REQ-038 req0 asserts r_en and w_en together.
- Expect MEM_W_EN=1, MEM_R_EN=0.
- Expect req0_rdata unchanged after completion.
REQ-039 rst asserted 2 cycles into BUSY.
- Expect next cycle state IDLE, all enables 0, no readyN pulse.
- Expect the subsequent simultaneous request granted to requester 0.
REQ-040 req1 becomes active while req0 is in BUSY.
- Expect req1 granted in the IDLE cycle after req0's RELEASE.
- Expect req1 request not lost.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-requester SRAM arbiter.
package sram_arbiter_pkg;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  typedef struct packed {
    logic              r_en;
    logic              w_en;
    logic              hit;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // A write always wins over a simultaneous read from the same requester.
  function automatic logic mem_read_en(input logic r_en, input logic w_en);
    return r_en & ~w_en;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of requester-side and SRAM-controller-side signals of the arbiter.
interface sram_arbiter_if;

  logic                               req0_r_en;
  logic                               req0_w_en;
  logic [sram_arbiter_pkg::ADDR_W-1:0] req0_addr;
  logic [sram_arbiter_pkg::DATA_W-1:0] req0_wdata;
  logic                               req0_hit;
  logic [sram_arbiter_pkg::DATA_W-1:0] req0_rdata;
  logic                               req0_ready;

  logic                               req1_r_en;
  logic                               req1_w_en;
  logic [sram_arbiter_pkg::ADDR_W-1:0] req1_addr;
  logic [sram_arbiter_pkg::DATA_W-1:0] req1_wdata;
  logic                               req1_hit;
  logic [sram_arbiter_pkg::DATA_W-1:0] req1_rdata;
  logic                               req1_ready;

  logic                               MEM_R_EN;
  logic                               MEM_W_EN;
  logic [sram_arbiter_pkg::ADDR_W-1:0] ALU_res;
  logic [sram_arbiter_pkg::DATA_W-1:0] ST_Value;
  logic                               hit;
  logic                               Ready;
  logic [sram_arbiter_pkg::DATA_W-1:0] read_data;
  logic                               grant;

  modport slave (
    input  req0_r_en, req0_w_en, req0_addr, req0_wdata, req0_hit,
    input  req1_r_en, req1_w_en, req1_addr, req1_wdata, req1_hit,
    input  Ready, read_data,
    output req0_rdata, req0_ready, req1_rdata, req1_ready,
    output MEM_R_EN, MEM_W_EN, ALU_res, ST_Value, hit, grant
  );

  modport master (
    output req0_r_en, req0_w_en, req0_addr, req0_wdata, req0_hit,
    output req1_r_en, req1_w_en, req1_addr, req1_wdata, req1_hit,
    output Ready, read_data,
    input  req0_rdata, req0_ready, req1_rdata, req1_ready,
    input  MEM_R_EN, MEM_W_EN, ALU_res, ST_Value, hit, grant
  );

endinterface

// File: rtl/sram_arbiter_rr_pick.sv
// Two-way round-robin select: a lone requester wins, on a tie the one
// that was not granted last wins.
module sram_arbiter_rr_pick (
  input  logic [1:0] active,
  input  logic       last_grant,
  output logic       winner,
  output logic       any
);

  // Winner index from the active vector and previous grant
  always_comb begin
    winner = 1'b0;
    case (active)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant;
      default: winner = 1'b0;
    endcase
  end

  assign any = |active;

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester SRAM arbiter: IDLE/BUSY/RELEASE handshake towards a single
// SRAM controller, round-robin grant, registered controller-side outputs.
module sram_arbiter
  import sram_arbiter_pkg::*;
(
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);

  req_t               req0_s;
  req_t               req1_s;
  req_t               win_req_s;
  logic [NUM_REQ-1:0] active_s;
  logic               win_s;
  logic               any_s;

  logic [1:0]         state_r;
  logic               grant_r;
  logic               last_grant_r;
  logic [NUM_REQ-1:0] ready_r;
  logic [DATA_W-1:0]  rdata0_r;
  logic [DATA_W-1:0]  rdata1_r;
  logic               mem_r_en_r;
  logic               mem_w_en_r;
  logic               hit_r;
  logic [ADDR_W-1:0]  alu_res_r;
  logic [DATA_W-1:0]  st_value_r;

  assign req0_s   = '{r_en: bus.req0_r_en, w_en: bus.req0_w_en, hit: bus.req0_hit,
                      addr: bus.req0_addr, wdata: bus.req0_wdata};
  assign req1_s   = '{r_en: bus.req1_r_en, w_en: bus.req1_w_en, hit: bus.req1_hit,
                      addr: bus.req1_addr, wdata: bus.req1_wdata};
  assign active_s = {req1_s.r_en | req1_s.w_en, req0_s.r_en | req0_s.w_en};

  sram_arbiter_rr_pick u_rr_pick (
    .active     (active_s),
    .last_grant (last_grant_r),
    .winner     (win_s),
    .any        (any_s)
  );

  // Request of the arbitration winner, only consumed in IDLE
  always_comb begin
    if (win_s) begin
      win_req_s = req1_s;
    end else begin
      win_req_s = req0_s;
    end
  end

  // Handshake FSM; controller-side outputs are captured on the grant edge and
  // held through BUSY, so a late request change cannot glitch the enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      ready_r      <= {NUM_REQ{1'b0}};
      rdata0_r     <= {DATA_W{1'b0}};
      rdata1_r     <= {DATA_W{1'b0}};
      mem_r_en_r   <= 1'b0;
      mem_w_en_r   <= 1'b0;
      hit_r        <= 1'b0;
      alu_res_r    <= {ADDR_W{1'b0}};
      st_value_r   <= {DATA_W{1'b0}};
    end else begin
      ready_r <= {NUM_REQ{1'b0}};
      case (state_r)
        IDLE: begin
          if (any_s) begin
            state_r    <= BUSY;
            grant_r    <= win_s;
            mem_w_en_r <= win_req_s.w_en;
            mem_r_en_r <= mem_read_en(win_req_s.r_en, win_req_s.w_en);
            hit_r      <= win_req_s.hit;
            alu_res_r  <= win_req_s.addr;
            st_value_r <= win_req_s.wdata;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (bus.Ready) begin
            state_r          <= RELEASE;
            last_grant_r     <= grant_r;
            ready_r[grant_r] <= 1'b1;
            mem_r_en_r       <= 1'b0;
            mem_w_en_r       <= 1'b0;
            hit_r            <= 1'b0;
            // Read data is kept across writes
            if (mem_r_en_r) begin
              if (grant_r) begin
                rdata1_r <= bus.read_data;
              end else begin
                rdata0_r <= bus.read_data;
              end
            end
          end else begin
            state_r <= BUSY;
          end
        end
        RELEASE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          mem_r_en_r <= 1'b0;
          mem_w_en_r <= 1'b0;
          hit_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MEM_R_EN   = mem_r_en_r;
  assign bus.MEM_W_EN   = mem_w_en_r;
  assign bus.hit        = hit_r;
  assign bus.ALU_res    = alu_res_r;
  assign bus.ST_Value   = st_value_r;
  assign bus.grant      = grant_r;
  assign bus.req0_ready = ready_r[0];
  assign bus.req1_ready = ready_r[1];
  assign bus.req0_rdata = rdata0_r;
  assign bus.req1_rdata = rdata1_r;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: requester drivers, an SRAM controller
// model with programmable latency, and a monitor checking each completion.
module tb_sram_arbiter;

  typedef struct {
    logic        idx;
    logic        r_en;
    logic        w_en;
    logic        hit;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_r;
    logic        mem_w;
    logic [31:0] rdata;
    int          lat;
    int          gap;
  } tx_t;

  logic clk;
  logic rst;
  sram_arbiter_if bus ();

  sram_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] lat_cfg = 8'd0;
  logic [7:0] rdy_cnt = 8'd0;
  tx_t txq0[$];
  tx_t txq1[$];
  tx_t expq[$];
  bit busy0 = 1'b0;
  bit busy1 = 1'b0;
  int load_cyc0 = 0;
  int load_cyc1 = 0;
  int pulses = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM controller model: Ready after lat_cfg extra enable cycles
  always @(posedge clk) begin
    if (rst || !(bus.MEM_R_EN || bus.MEM_W_EN)) rdy_cnt <= 8'd0;
    else rdy_cnt <= rdy_cnt + 8'd1;
  end
  assign bus.Ready     = (bus.MEM_R_EN || bus.MEM_W_EN) && (rdy_cnt == lat_cfg);
  assign bus.read_data = bus.ALU_res ^ 32'h1234_5600;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic tx_t mk(input logic idx, input logic r, input logic w, input logic h,
                             input logic [31:0] a, input logic [31:0] d, input logic mr,
                             input logic mw, input logic [31:0] rd, input int lat, input int gap);
    tx_t t;
    t.idx = idx; t.r_en = r; t.w_en = w; t.hit = h; t.addr = a; t.wdata = d;
    t.mem_r = mr; t.mem_w = mw; t.rdata = rd; t.lat = lat; t.gap = gap;
    return t;
  endfunction

  task automatic issue(input tx_t t, input bit track);
    if (t.idx) txq1.push_back(t);
    else txq0.push_back(t);
    if (track) expq.push_back(t);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((expq.size() != 0 || txq0.size() != 0 || txq1.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(expq.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_en(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.MEM_R_EN || bus.MEM_W_EN) && n < budget);
    chk("wait_enable", 32'(bus.MEM_R_EN || bus.MEM_W_EN), 32'd1);
  endtask

  // Requester drivers: present queued requests, drop them after the ready pulse
  initial begin
    tx_t t;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        busy0 = 1'b0; busy1 = 1'b0;
        bus.req0_r_en = 1'b0; bus.req0_w_en = 1'b0;
        bus.req1_r_en = 1'b0; bus.req1_w_en = 1'b0;
      end else begin
        if (busy0 && bus.req0_ready) begin
          busy0 = 1'b0; bus.req0_r_en = 1'b0; bus.req0_w_en = 1'b0;
        end
        if (!busy0 && txq0.size() > 0) begin
          t = txq0.pop_front();
          bus.req0_r_en = t.r_en; bus.req0_w_en = t.w_en; bus.req0_hit = t.hit;
          bus.req0_addr = t.addr; bus.req0_wdata = t.wdata;
          busy0 = 1'b1; load_cyc0 = cyc;
        end
        if (busy1 && bus.req1_ready) begin
          busy1 = 1'b0; bus.req1_r_en = 1'b0; bus.req1_w_en = 1'b0;
        end
        if (!busy1 && txq1.size() > 0) begin
          t = txq1.pop_front();
          bus.req1_r_en = t.r_en; bus.req1_w_en = t.w_en; bus.req1_hit = t.hit;
          bus.req1_addr = t.addr; bus.req1_wdata = t.wdata;
          busy1 = 1'b1; load_cyc1 = cyc;
        end
      end
    end
  end

  // Monitor: record the BUSY window, score it on each ready pulse
  initial begin
    tx_t e;
    logic [31:0] cap_addr, cap_st;
    logic cap_r, cap_w, cap_h, idx;
    int acc_n = 0;
    bit unstable = 1'b0;
    int last_rdy = 0;
    int ld;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_n = 0; unstable = 1'b0;
      end else begin
        if (bus.MEM_R_EN || bus.MEM_W_EN) begin
          if (acc_n == 0) begin
            cap_addr = bus.ALU_res; cap_st = bus.ST_Value;
            cap_r = bus.MEM_R_EN; cap_w = bus.MEM_W_EN; cap_h = bus.hit;
          end else if (bus.ALU_res !== cap_addr || bus.ST_Value !== cap_st ||
                       bus.MEM_R_EN !== cap_r || bus.MEM_W_EN !== cap_w || bus.hit !== cap_h) begin
            unstable = 1'b1;
          end
          acc_n++;
        end
        if (bus.req0_ready || bus.req1_ready) begin
          pulses++;
          idx = bus.req1_ready;
          chk("ready_onehot", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
          chk("pending_tx", 32'(expq.size() != 0), 32'd1);
          if (expq.size() != 0) begin
            e = expq.pop_front();
            ld = idx ? load_cyc1 : load_cyc0;
            chk("ready_idx", 32'(idx), 32'(e.idx));
            chk("grant", 32'(bus.grant), 32'(e.idx));
            chk("mem_w_en", 32'(cap_w), 32'(e.mem_w));
            chk("mem_r_en", 32'(cap_r), 32'(e.mem_r));
            chk("hit_fwd", 32'(cap_h), 32'(e.hit));
            chk("alu_res", cap_addr, e.addr);
            chk("st_value", cap_st, e.wdata);
            chk("rdata", idx ? bus.req1_rdata : bus.req0_rdata, e.rdata);
            chk("busy_cycles", 32'(acc_n), 32'(lat_cfg) + 32'd1);
            chk("busy_stable", 32'(unstable), 32'd0);
            chk("enables_low_release", 32'(bus.MEM_R_EN || bus.MEM_W_EN), 32'd0);
            if (e.lat >= 0) chk("latency", 32'(cyc - ld), 32'(e.lat));
            if (e.gap >= 0) chk("gap", 32'(cyc - last_rdy), 32'(e.gap));
          end
          last_rdy = cyc;
          acc_n = 0;
          unstable = 1'b0;
        end
      end
    end
  end

  initial begin
    int pulses_before;
    rst = 1'b1;
    bus.req0_r_en = 1'b0; bus.req0_w_en = 1'b0; bus.req0_hit = 1'b0;
    bus.req0_addr = 32'd0; bus.req0_wdata = 32'd0;
    bus.req1_r_en = 1'b0; bus.req1_w_en = 1'b0; bus.req1_hit = 1'b0;
    bus.req1_addr = 32'd0; bus.req1_wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_mem_r_en", 32'(bus.MEM_R_EN), 32'd0);
    chk("rst_mem_w_en", 32'(bus.MEM_W_EN), 32'd0);
    chk("rst_alu_res", bus.ALU_res, 32'd0);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    chk("rst_rdata0", bus.req0_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Write from requester 0, controller answers after 6 extra cycles
    lat_cfg = 8'd6;
    issue(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0, 8, -1), 1'b1);
    drain(60);

    // Read hit from requester 1, Ready in the first BUSY cycle
    lat_cfg = 8'd0;
    issue(mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0078, 32'h0, 1'b1, 1'b0, 32'h1234_5678, 2, -1), 1'b1);
    drain(40);

    // Both reading continuously: grants alternate 0,1,0,1
    lat_cfg = 8'd1;
    issue(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 1'b0, 32'h1234_5610, 3, -1), 1'b1);
    issue(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 1'b1, 1'b0, 32'h1234_5620, -1, 4), 1'b1);
    issue(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0030, 32'h0, 1'b1, 1'b0, 32'h1234_5630, -1, 4), 1'b1);
    issue(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 1'b1, 1'b0, 32'h1234_5644, -1, 4), 1'b1);
    drain(80);

    // Read and write together: write wins, rdata kept
    lat_cfg = 8'd2;
    issue(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h1234_5630, 4, -1), 1'b1);
    drain(40);

    // Reset two cycles into BUSY: transaction abandoned, no ready pulse
    lat_cfg = 8'd10;
    issue(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0500, 32'h1111_1111, 1'b1, 1'b0, 32'h0, -1, -1), 1'b0);
    wait_en(20);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_mem_r_en", 32'(bus.MEM_R_EN), 32'd0);
    chk("midrst_mem_w_en", 32'(bus.MEM_W_EN), 32'd0);
    chk("midrst_hit", 32'(bus.hit), 32'd0);
    chk("midrst_alu_res", bus.ALU_res, 32'd0);
    chk("midrst_st_value", bus.ST_Value, 32'd0);
    chk("midrst_grant", 32'(bus.grant), 32'd0);
    chk("midrst_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    chk("midrst_rdata0", bus.req0_rdata, 32'd0);
    chk("midrst_rdata1", bus.req1_rdata, 32'd0);
    pulses_before = pulses;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_no_pulse", 32'(pulses), 32'(pulses_before));

    // First simultaneous request after reset goes to requester 0
    lat_cfg = 8'd0;
    issue(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_000C, 32'h0, 1'b1, 1'b0, 32'h1234_560C, 2, -1), 1'b1);
    issue(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_001C, 32'h0, 1'b1, 1'b0, 32'h1234_561C, -1, 3), 1'b1);
    drain(40);

    // Requester 1 arrives while requester 0 is in BUSY
    lat_cfg = 8'd3;
    issue(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0600, 32'h0BAD_CAFE, 1'b0, 1'b1, 32'h1234_560C, 5, -1), 1'b1);
    wait_en(20);
    @(negedge clk);
    issue(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0064, 32'h0, 1'b1, 1'b0, 32'h1234_5664, -1, 6), 1'b1);
    drain(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
